// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding,
// the DIV/DIVU operation codes alongside the neighbouring ALU op codes,
// and a magnitude helper used when latching signed operands.
package div_iter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_BYZERO = 2'b01,
        S_DIV_ON = 2'b10,
        S_END    = 2'b11
    } div_state_e;

    // ALU operation codes; DIV/DIVU select the double HI/LO write.
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_MULT_OP = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam int unsigned DIV_STEPS = 32;

    // Magnitude of a 32-bit operand; raw value when the divide is unsigned.
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider (DIV / DIVU). One shift-subtract step
// per cycle; result = {remainder, quotient} feeds the HI/LO write path.
import div_iter_pkg::*;

module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic [63:0] result,
    output logic        ready,
    output logic        busy
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] acc_q, acc_d;       // {partial remainder[64:32], quotient/dividend[31:0]}
    logic [31:0] divisor_q, divisor_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [65:0] shifted;
    logic [33:0] diff;
    logic [64:0] step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // One restoring step on the current accumulator, plus the sign fix-up
    // of what the accumulator becomes after that step.
    always_comb begin
        shifted = {acc_q, 1'b0};
        diff    = shifted[65:32] - {2'b00, divisor_q};
        if (diff[33]) begin
            step = shifted[64:0];
        end else begin
            step = {diff[32:0], shifted[31:1], 1'b1};
        end
        quo_fix = quo_neg_q ? (32'd0 - step[31:0])  : step[31:0];
        rem_fix = rem_neg_q ? (32'd0 - step[63:32]) : step[63:32];
    end

    // Next-state, datapath and output decode; annul abandons any in-flight work.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        divisor_d = divisor_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        busy      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    busy = 1'b1;
                    if (opdata2 == 32'd0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d   = S_DIV_ON;
                        cnt_d     = 6'd0;
                        acc_d     = {33'd0, mag32(opdata1, signed_div)};
                        divisor_d = mag32(opdata2, signed_div);
                        quo_neg_d = signed_div & (opdata1[31] ^ opdata2[31]);
                        rem_neg_d = signed_div & opdata1[31];
                    end
                end
            end
            S_BYZERO: begin
                busy = 1'b1;
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = 64'h0;
                end
            end
            S_DIV_ON: begin
                busy = 1'b1;
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_STEPS - 1)) begin
                        state_d  = S_END;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            S_END: begin
                if (annul || !start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_END);
    end

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 65'd0;
            divisor_q <= 32'd0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= 64'h0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            divisor_q <= divisor_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule
